// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: shared state encoding, SRAM bus widths and address mapping
package sram_controller_pkg;
    localparam int LEN_SRAM_ADDRESS = 18;
    localparam int LEN_SRAM_DATA = 16;
    localparam int MEM_BASE_DEFAULT = 1024;
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
    function automatic logic [16:0] word_index(input logic [31:0] address, input logic [31:0] base);
        return 17'((address - base) >> 2);
    endfunction
endpackage

// File: rtl/sram_phase_counter.sv
// sram_phase_counter: times one SRAM phase and pulses done on its last cycle
module sram_phase_counter #(
    parameter int SRAM_WAIT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic done
);
    logic [3:0] wait_cnt;
    assign done = active && wait_cnt == 4'(SRAM_WAIT - 1);
    // count while a phase runs, clear on its last cycle or whenever no phase is active
    always_ff @(posedge clk)
        if (rst || !active || done) wait_cnt <= '0;
        else wait_cnt <= wait_cnt + 4'd1;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit loads/stores into two timed 16-bit SRAM accesses
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int SRAM_WAIT = 5,
    parameter int MEM_BASE = MEM_BASE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_en,
    input  logic                        wr_en,
    input  logic [31:0]                 address,
    input  logic [31:0]                 write_data,
    output logic [31:0]                 read_data,
    output logic                        ready,
    output logic [LEN_SRAM_ADDRESS-1:0] sram_addr,
    output logic [LEN_SRAM_DATA-1:0]    sram_dq_out,
    output logic                        sram_dq_oe,
    input  logic [LEN_SRAM_DATA-1:0]    sram_dq_in,
    output logic                        sram_we_n
);
    state_t state, next;
    logic [16:0] word;
    logic [31:0] data;
    logic [15:0] lo_half;
    logic done, phase, write, high, request;
    assign request = rd_en | wr_en;
    assign phase = state inside {RD_LO, RD_HI, WR_LO, WR_HI};
    assign write = state inside {WR_LO, WR_HI};
    assign high = state inside {RD_HI, WR_HI};
    assign ready = state == DONE || (state == IDLE && !request);
    assign sram_addr = phase ? {word, high} : '0;
    assign sram_dq_out = write ? (high ? data[31:16] : data[15:0]) : '0;
    assign sram_dq_oe = write;
    assign sram_we_n = !write;
    sram_phase_counter #(.SRAM_WAIT(SRAM_WAIT)) u_cnt (
        .clk(clk),
        .rst(rst),
        .active(phase),
        .done(done)
    );
    // next state: a simultaneous read and write is executed as a write
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = wr_en ? WR_LO : rd_en ? RD_LO : IDLE;
            RD_LO:   next = done ? RD_HI : RD_LO;
            RD_HI:   next = done ? DONE : RD_HI;
            WR_LO:   next = done ? WR_HI : WR_LO;
            WR_HI:   next = done ? DONE : WR_HI;
            default: next = IDLE;
        endcase
    end
    // state register and load result, which only changes when the high half arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            read_data <= '0;
        end else begin
            state <= next;
            if (state == RD_HI && done) read_data <= {sram_dq_in, lo_half};
        end
    end
    // request latches: address and data are frozen on leaving IDLE, low half held until the high half lands
    always_ff @(posedge clk) begin
        if (state == IDLE && request) begin
            word <= word_index(address, 32'(MEM_BASE));
            data <= write_data;
        end
        if (state == RD_LO && done) lo_half <= sram_dq_in;
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: table-driven load/store checks with a read-result scoreboard
module tb_sram_controller;
    localparam int W = 5;
    localparam int BASE = 1024;
    logic clk = 0, rst = 1;
    logic rd_en = 0, wr_en = 0, rd_en1 = 0, wr_en1 = 0;
    logic [31:0] address = 0, write_data = 0, read_data, read_data1;
    logic ready, ready1, sram_dq_oe, sram_dq_oe1, sram_we_n, sram_we_n1;
    logic [17:0] sram_addr, sram_addr1;
    logic [15:0] sram_dq_out, sram_dq_out1, sram_dq_in;
    logic [15:0] sram_dq_in1 = 16'h0;
    logic [15:0] sram_mem [0:262143];
    logic [31:0] sb[$];
    int errors = 0, checks = 0;
    typedef struct {
        logic rd;
        logic wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic gap;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

    sram_controller #(.SRAM_WAIT(W), .MEM_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_controller #(.SRAM_WAIT(1), .MEM_BASE(BASE)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address),
        .write_data(write_data), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        rd_en = 0;
        wr_en = 0;
        @(negedge clk);
        chk("idle_ready", ready, 1);
    endtask

    task automatic txn(input vec_t v);
        int n;
        logic [31:0] off;
        logic [17:0] base;
        logic [15:0] half;
        logic [35:0] exp_bus;
        @(posedge clk); #1;
        rd_en = v.rd;
        wr_en = v.wr;
        address = v.addr;
        write_data = v.data;
        off = (v.addr - 32'(BASE)) >> 2;
        base = {off[16:0], 1'b0};
        if (!v.wr) sb.push_back(v.exp);
        n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            if (n > 0) begin
                half = n <= W ? v.data[15:0] : v.data[31:16];
                exp_bus = v.wr ? {base | 18'(n > W), half, 1'b0, 1'b1}
                               : {base | 18'(n > W), 16'h0, 1'b1, 1'b0};
                chk("phase_bus", {sram_addr, sram_dq_out, sram_we_n, sram_dq_oe}, exp_bus);
            end
            n++;
            @(negedge clk);
        end
        chk("freeze_cycles", n, 2 * W + 1);
        if (!v.wr) begin
            if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
            else chk("read_data", read_data, sb.pop_front());
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{0, 1, 32'd1024, 32'hDEADBEEF, 32'h0, 1};
        tbl[1] = '{1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 1};
        tbl[2] = '{0, 1, 32'd1028, 32'h12345678, 32'h0, 0};
        tbl[3] = '{1, 0, 32'd1028, 32'h0, 32'h12345678, 1};
        tbl[4] = '{0, 1, 32'd0, 32'hCAFEF00D, 32'h0, 1};
        tbl[5] = '{1, 0, 32'd0, 32'h0, 32'hCAFEF00D, 0};
        tbl[6] = '{1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 1};
        tbl[7] = '{1, 1, 32'd1032, 32'hA5A55A5A, 32'h0, 1};
        tbl[8] = '{1, 0, 32'd1032, 32'h0, 32'hA5A55A5A, 1};
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_read_data", read_data, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe", sram_dq_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        @(posedge clk); #1;
        wr_en = 1;
        address = 32'd1036;
        write_data = 32'h11112222;
        repeat (7) @(posedge clk);
        #1;
        rst = 1;
        wr_en = 0;
        @(negedge clk);
        chk("mid_write_we_n", sram_we_n, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_oe", sram_dq_oe, 0);
        chk("abort_ready", ready, 1);
        chk("abort_read_data", read_data, 0);
        for (int i = 0; i < 9; i++) begin
            txn(tbl[i]);
            if (tbl[i].gap) idle_cycle();
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(posedge clk); #1;
        rd_en1 = 1;
        wr_en1 = 1;
        address = 32'd1040;
        write_data = 32'h0BADF00D;
        n = 0;
        @(negedge clk);
        while (!ready1 && n < 20) begin
            if (n > 0) chk("w1_we_n", {sram_we_n1, sram_dq_oe1}, 2'b01);
            if (n == 1) chk("w1_lo", {sram_addr1, sram_dq_out1}, {18'd8, 16'hF00D});
            if (n == 2) chk("w1_hi", {sram_addr1, sram_dq_out1}, {18'd9, 16'h0BAD});
            n++;
            @(negedge clk);
        end
        chk("w1_freeze_cycles", n, 3);
        @(posedge clk); #1;
        rd_en1 = 0;
        wr_en1 = 0;
        @(negedge clk);
        chk("w1_idle_ready", ready1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
